addsub_sched: RTL and testbench

Two-requester scheduler for the team's shared WIDTH-bit add/subtract datapath (ADDSUB). It arbitrates between two clients with round-robin priority and captures the winner's operands and operation select. It sequences one operation through the datapath and returns the registered Sum/Carry/Overflow with the requester ID under a valid/ready handshake. It sits between the two operand sources and the shared ADDSUB instance, which it instantiates internally.

---
 rtl/addsub_sched.sv | 181 ++++++++++++++++++
 tb/tb_addsub_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_sched.sv
// addsub_sched: two-requester round-robin scheduler in front of a shared
// WIDTH-bit add/subtract datapath. One operation is in flight at a time:
// IDLE grants a requester and latches its operands, EXEC lets the datapath
// compute and registers the result, and RESULT holds the result until the
// consumer accepts it.
//
// Optional feature: define ADDSUB_SCHED_STATS_EN to add the cnt0/cnt1
// accept counters and the ovf_cnt overflow-delivery counter.

// Shared add/subtract datapath: subtraction is A + ~B + 1, overflow is the
// carry into the MSB XOR the carry out of the MSB.
module addsub_dp #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             ovf
);

   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] low_sum;   // low WIDTH-1 bits plus carry into the MSB
   logic [WIDTH:0]   full_sum;  // full result plus carry out of the MSB

   assign b_eff    = sel ? ~b : b;
   assign low_sum  = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
                   + {{(WIDTH-1){1'b0}}, sel};
   assign full_sum = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sel};

   assign sum   = full_sum[WIDTH-1:0];
   assign carry = full_sum[WIDTH];
   assign ovf   = full_sum[WIDTH] ^ low_sum[WIDTH-1];

endmodule

module addsub_sched #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             sel0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   input  logic             sel1,
   output logic             ack0,
   output logic             ack1,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_id,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_carry,
   output logic             res_ovf
`ifdef ADDSUB_SCHED_STATS_EN
  ,output logic [7:0]       cnt0
  ,output logic [7:0]       cnt1
  ,output logic [7:0]       ovf_cnt
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXEC   = 2'd1,
      RESULT = 2'd2
   } state_t;

   state_t           state;
   logic             prio;      // 0: requester 0 wins a tie, 1: requester 1 wins
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_sel;
   logic             op_id;

   logic             grant0;
   logic             grant1;

   logic [WIDTH-1:0] dp_sum;
   logic             dp_carry;
   logic             dp_ovf;

   // Round-robin grant decision; only IDLE issues grants, and never while reset is held.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && state == IDLE) begin
         if (req0 && req1) begin
            if (prio) grant1 = 1'b1;
            else      grant0 = 1'b1;
         end else if (req0) begin
            grant0 = 1'b1;
         end else if (req1) begin
            grant1 = 1'b1;
         end
      end
   end

   assign ack0 = grant0;
   assign ack1 = grant1;

   addsub_dp #(.WIDTH(WIDTH)) u_dp (
      .a     (op_a),
      .b     (op_b),
      .sel   (op_sel),
      .sum   (dp_sum),
      .carry (dp_carry),
      .ovf   (dp_ovf)
   );

   // Operation sequencer: latch the winner, register the datapath result, hold until accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is written with non-blocking assignments so every flop samples the pre-edge values.
      if (!rst_n) begin
         state     <= IDLE;
         prio      <= 1'b0;
         op_a      <= '0;
         op_b      <= '0;
         op_sel    <= 1'b0;
         op_id     <= 1'b0;
         res_valid <= 1'b0;
         res_id    <= 1'b0;
         res_sum   <= '0;
         res_carry <= 1'b0;
         res_ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 || grant1) begin
                  op_a   <= grant1 ? a1   : a0;
                  op_b   <= grant1 ? b1   : b0;
                  op_sel <= grant1 ? sel1 : sel0;
                  op_id  <= grant1;
                  // The requester just served loses the next tie.
                  prio   <= grant0;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               res_sum   <= dp_sum;
               res_carry <= dp_carry;
               res_ovf   <= dp_ovf;
               res_id    <= op_id;
               res_valid <= 1'b1;
               state     <= RESULT;
            end
            RESULT: begin
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               res_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

`ifdef ADDSUB_SCHED_STATS_EN
   // Accept counters per requester and count of delivered overflowing results, wrapping at 256.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0    <= 8'd0;
         cnt1    <= 8'd0;
         ovf_cnt <= 8'd0;
      end else begin
         if (grant0) cnt0 <= cnt0 + 8'd1;
         if (grant1) cnt1 <= cnt1 + 8'd1;
         if (state == RESULT && res_valid && res_ready && res_ovf)
            ovf_cnt <= ovf_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_addsub_sched.sv
// Directed bench for addsub_sched (WIDTH=4). Inputs are driven just after the
// falling edge and outputs are sampled in the low phase, away from the rising
// edge. Counter checks are compiled in only with ADDSUB_SCHED_STATS_EN.
module tb_addsub_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req0 = 1'b0;
   logic       req1 = 1'b0;
   logic [3:0] a0 = '0;
   logic [3:0] b0 = '0;
   logic [3:0] a1 = '0;
   logic [3:0] b1 = '0;
   logic       sel0 = 1'b0;
   logic       sel1 = 1'b0;
   logic       res_ready = 1'b0;
   logic       ack0;
   logic       ack1;
   logic       res_valid;
   logic       res_id;
   logic [3:0] res_sum;
   logic       res_carry;
   logic       res_ovf;
`ifdef ADDSUB_SCHED_STATS_EN
   logic [7:0] cnt0;
   logic [7:0] cnt1;
   logic [7:0] ovf_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   addsub_sched #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0      (req0),
      .a0        (a0),
      .b0        (b0),
      .sel0      (sel0),
      .req1      (req1),
      .a1        (a1),
      .b1        (b1),
      .sel1      (sel1),
      .ack0      (ack0),
      .ack1      (ack1),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_sum   (res_sum),
      .res_carry (res_carry),
      .res_ovf   (res_ovf)
`ifdef ADDSUB_SCHED_STATS_EN
     ,.cnt0      (cnt0)
     ,.cnt1      (cnt1)
     ,.ovf_cnt   (ovf_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1, "watchdog");
   end

   // Move to the next sample point (1 time unit after the falling edge).
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Wait until the selected ack is high, at most 'bound' cycles.
   task automatic wait_ack(input bit r, input int bound, output bit got, output int waited);
      got = 1'b0;
      waited = 0;
      for (int i = 0; i < bound; i++) begin
         if ((r ? ack1 : ack0) === 1'b1) begin
            got = 1'b1;
            break;
         end
         step();
         waited++;
      end
   endtask

   // Raise a request with its operands and wait for its ack.
   task automatic issue(input bit r, input logic [3:0] a, input logic [3:0] b, input logic s,
                        output bit got, output int waited);
      step();
      if (r) begin
         req1 = 1'b1; a1 = a; b1 = b; sel1 = s;
      end else begin
         req0 = 1'b1; a0 = a; b0 = b; sel0 = s;
      end
      #1;
      wait_ack(r, 20, got, waited);
   endtask

   task automatic pulse_reset();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      res_ready = 1'b1;
      req0 = 1'b1; a0 = 4'b0000; b0 = 4'b0000; sel0 = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      step();
      n_total++;
      if (ack0 !== 1'b0) $display("FAIL rst_ack0: got %b want 0", ack0); else n_pass++;
      n_total++;
      if (ack1 !== 1'b0) $display("FAIL rst_ack1: got %b want 0", ack1); else n_pass++;
      n_total++;
      if (res_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", res_valid); else n_pass++;
      n_total++;
      if ({res_id, res_sum, res_carry, res_ovf} !== 7'b0)
         $display("FAIL rst_result: got id=%b sum=%b c=%b o=%b want all 0", res_id, res_sum, res_carry, res_ovf);
      else n_pass++;
`ifdef ADDSUB_SCHED_STATS_EN
      n_total++;
      if ({cnt0, cnt1, ovf_cnt} !== 24'd0)
         $display("FAIL rst_counters: got %0d %0d %0d want 0 0 0", cnt0, cnt1, ovf_cnt);
      else n_pass++;
`endif
      // Release in the low phase: ack0 must appear in the first cycle.
      step();
      rst_n = 1'b1;
      #1;
      n_total++;
      if (ack0 !== 1'b1) $display("FAIL rst_release_ack0: got %b want 1", ack0); else n_pass++;
   endtask

   // Continues the operation acked at the end of test_reset (0000 + 0000).
   task automatic test_add_zero();
      step();
      req0 = 1'b0;
      n_total++;
      if (res_valid !== 1'b0) $display("FAIL zero_valid_t1: got %b want 0", res_valid); else n_pass++;
      step();
      n_total++;
      if (res_valid !== 1'b1) $display("FAIL zero_valid_t2: got %b want 1", res_valid); else n_pass++;
      n_total++;
      if ({res_id, res_sum, res_carry, res_ovf} !== 7'b0_0000_0_0)
         $display("FAIL zero_result: got id=%b sum=%b c=%b o=%b want id=0 sum=0000 c=0 o=0",
                  res_id, res_sum, res_carry, res_ovf);
      else n_pass++;
   endtask

   task automatic test_sub();
      bit got;
      int waited;
      issue(1'b1, 4'b1000, 4'b0101, 1'b1, got, waited);
      n_total++;
      if (got !== 1'b1) $display("FAIL sub1_ack: got %b want 1", got); else n_pass++;
      step();
      req1 = 1'b0;
      step();
      n_total++;
      if ({res_valid, res_id, res_sum, res_carry, res_ovf} !== 8'b1_1_0011_1_1)
         $display("FAIL sub1_result: got v=%b id=%b sum=%b c=%b o=%b want v=1 id=1 sum=0011 c=1 o=1",
                  res_valid, res_id, res_sum, res_carry, res_ovf);
      else n_pass++;
      // Next request arrives in the first IDLE cycle: granted without delay.
      issue(1'b1, 4'b1111, 4'b1000, 1'b1, got, waited);
      n_total++;
      if (got !== 1'b1 || waited !== 0) $display("FAIL sub2_ack: got %b after %0d cycles want 1 after 0", got, waited);
      else n_pass++;
      step();
      req1 = 1'b0;
      step();
      n_total++;
      if ({res_valid, res_id, res_sum, res_carry, res_ovf} !== 8'b1_1_0111_1_0)
         $display("FAIL sub2_result: got v=%b id=%b sum=%b c=%b o=%b want v=1 id=1 sum=0111 c=1 o=0",
                  res_valid, res_id, res_sum, res_carry, res_ovf);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      bit exp_id [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      int last_cyc;
      bit got;
      step();
      req0 = 1'b1; a0 = 4'b0001; b0 = 4'b0001; sel0 = 1'b0;
      req1 = 1'b1; a1 = 4'b0010; b1 = 4'b0001; sel1 = 1'b1;
      #1;
      last_cyc = 0;
      for (int k = 0; k < 4; k++) begin
         got = 1'b0;
         for (int i = 0; i < 10; i++) begin
            if (ack0 === 1'b1 || ack1 === 1'b1) begin
               got = 1'b1;
               break;
            end
            step();
         end
         n_total++;
         if (got !== 1'b1 || {ack1, ack0} !== (exp_id[k] ? 2'b10 : 2'b01))
            $display("FAIL rr_ack_%0d: got ack1,ack0=%b%b want %s", k, ack1, ack0, exp_id[k] ? "10" : "01");
         else n_pass++;
         if (k > 0) begin
            n_total++;
            if (cyc - last_cyc !== 3) $display("FAIL rr_spacing_%0d: got %0d cycles want 3", k, cyc - last_cyc);
            else n_pass++;
         end
         last_cyc = cyc;
         step();
         step();
         n_total++;
         if ({res_valid, res_id, res_sum} !== {1'b1, exp_id[k], 4'b0010 >> exp_id[k]})
            $display("FAIL rr_result_%0d: got v=%b id=%b sum=%b want v=1 id=%b sum=%b", k,
                     res_valid, res_id, res_sum, exp_id[k], 4'b0010 >> exp_id[k]);
         else n_pass++;
         if (k == 3) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
         step();
      end
   endtask

   task automatic test_backpressure();
      bit got;
      int waited;
      bit saw_ack;
      step();
      res_ready = 1'b0;
      issue(1'b0, 4'b0100, 4'b0100, 1'b0, got, waited);
      n_total++;
      if (got !== 1'b1) $display("FAIL bp_ack0: got %b want 1", got); else n_pass++;
      step();
      req0 = 1'b0;
      req1 = 1'b1; a1 = 4'b0001; b1 = 4'b0001; sel1 = 1'b0;
      step();
      n_total++;
      if ({res_valid, res_id, res_sum, res_carry, res_ovf} !== 8'b1_0_1000_0_1)
         $display("FAIL bp_result: got v=%b id=%b sum=%b c=%b o=%b want v=1 id=0 sum=1000 c=0 o=1",
                  res_valid, res_id, res_sum, res_carry, res_ovf);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         step();
         n_total++;
         if ({res_valid, res_id, res_sum, res_carry, res_ovf} !== 8'b1_0_1000_0_1 || ack1 !== 1'b0)
            $display("FAIL bp_hold_%0d: got v=%b id=%b sum=%b c=%b o=%b ack1=%b want 1 0 1000 0 1 ack1=0",
                     i, res_valid, res_id, res_sum, res_carry, res_ovf, ack1);
         else n_pass++;
      end
      step();
      res_ready = 1'b1;
      #1;
      saw_ack = ack1;
      step();
      n_total++;
      if (saw_ack !== 1'b0 || ack1 !== 1'b1)
         $display("FAIL bp_release_ack1: got %b in RESULT, %b in IDLE want 0 then 1", saw_ack, ack1);
      else n_pass++;
      step();
      req1 = 1'b0;
      step();
      n_total++;
      if ({res_valid, res_id, res_sum, res_carry, res_ovf} !== 8'b1_1_0010_0_0)
         $display("FAIL bp_next_result: got v=%b id=%b sum=%b c=%b o=%b want v=1 id=1 sum=0010 c=0 o=0",
                  res_valid, res_id, res_sum, res_carry, res_ovf);
      else n_pass++;
      step();
   endtask

   task automatic test_drop_req();
      bit got;
      int waited;
      bit saw_ack;
      res_ready = 1'b0;
      issue(1'b1, 4'b0011, 4'b0001, 1'b0, got, waited);
      step();
      req1 = 1'b0;
      step();
      // In RESULT: a brief request that goes away before any grant.
      req0 = 1'b1; a0 = 4'b1111; b0 = 4'b1111; sel0 = 1'b0;
      step();
      req0 = 1'b0;
      res_ready = 1'b1;
      saw_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (ack0 === 1'b1 || ack1 === 1'b1) saw_ack = 1'b1;
      end
      n_total++;
      if (got !== 1'b1 || saw_ack !== 1'b0 || res_valid !== 1'b0)
         $display("FAIL drop_req: got first_ack=%b stray_ack=%b valid=%b want 1 0 0", got, saw_ack, res_valid);
      else n_pass++;
   endtask

`ifdef ADDSUB_SCHED_STATS_EN
   task automatic test_stats();
      int n;
      pulse_reset();
      res_ready = 1'b1;
      req0 = 1'b1; a0 = 4'b0111; b0 = 4'b0001; sel0 = 1'b0;
      #1;
      n = 0;
      for (int i = 0; i < 2000; i++) begin
         if (ack0 === 1'b1) n++;
         if (n == 300) break;
         step();
      end
      step();
      req0 = 1'b0;
      repeat (4) step();
      n_total++;
      if (n !== 300) $display("FAIL stats_acks: got %0d want 300", n); else n_pass++;
      n_total++;
      if (cnt0 !== 8'd44) $display("FAIL stats_cnt0: got %0d want 44", cnt0); else n_pass++;
      n_total++;
      if (cnt1 !== 8'd0) $display("FAIL stats_cnt1: got %0d want 0", cnt1); else n_pass++;
      n_total++;
      if (ovf_cnt !== 8'd44) $display("FAIL stats_ovf_cnt: got %0d want 44", ovf_cnt); else n_pass++;
   endtask
`endif

   task automatic test_reset_mid_op();
      bit got;
      int waited;
      bit saw_valid;
      step();
      res_ready = 1'b1;
      issue(1'b0, 4'b0111, 4'b0001, 1'b0, got, waited);
      step();
      req0 = 1'b0;
      rst_n = 1'b0;
      #1;
      n_total++;
      if (got !== 1'b1 || res_valid !== 1'b0 || ack0 !== 1'b0)
         $display("FAIL midrst_state: got ack=%b valid=%b ack0=%b want 1 0 0", got, res_valid, ack0);
      else n_pass++;
`ifdef ADDSUB_SCHED_STATS_EN
      n_total++;
      if ({cnt0, cnt1, ovf_cnt} !== 24'd0)
         $display("FAIL midrst_counters: got %0d %0d %0d want 0 0 0", cnt0, cnt1, ovf_cnt);
      else n_pass++;
`endif
      step();
      rst_n = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (res_valid !== 1'b0) saw_valid = 1'b1;
      end
      n_total++;
      if (saw_valid !== 1'b0) $display("FAIL midrst_no_result: got valid=1 want 0"); else n_pass++;
      // Pointer is back to favouring requester 0.
      req0 = 1'b1; a0 = 4'b0001; b0 = 4'b0001; sel0 = 1'b0;
      req1 = 1'b1; a1 = 4'b0001; b1 = 4'b0001; sel1 = 1'b0;
      #1;
      n_total++;
      if ({ack1, ack0} !== 2'b01) $display("FAIL midrst_pointer: got ack1,ack0=%b%b want 01", ack1, ack0);
      else n_pass++;
      step();
      req0 = 1'b0;
      req1 = 1'b0;
      repeat (3) step();
   endtask

   initial begin
      test_reset();
      test_add_zero();
      test_sub();
      test_round_robin();
      test_backpressure();
      test_drop_req();
`ifdef ADDSUB_SCHED_STATS_EN
      test_stats();
`endif
      test_reset_mid_op();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
